// File: rtl/seq_mult_n.sv
// seq_mult_n: parametrised sequential shift-add multiplier.
// Reuses a single N+1 bit adder over N cycles. Operands may be unsigned or
// two's-complement, selected per operation by TC. Signed operands are
// converted to magnitudes at start and the product sign is applied at the end.
//
// Ports:
//   clk    - system clock, all state updates on the rising edge
//   rst_n  - synchronous active-low reset
//   start  - request a multiply, honoured only while busy is low
//   TC     - 0: unsigned operands, 1: two's-complement operands
//   A, B   - multiplicand / multiplier (N bits), captured with start
//   P      - 2N-bit product register, held until the next completion
//   busy   - high while an operation is in progress
//   done   - one-cycle pulse, P is updated in the same cycle
module seq_mult_n #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           TC,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] P,
  output logic           busy,
  output logic           done
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  state_t           state_q;
  logic [N-1:0]     mcand_q;
  logic [2*N:0]     acc_q;    // [2N:N] partial sum, [N-1:0] remaining multiplier bits
  logic [CW-1:0]    cnt_q;
  logic             neg_q;
  logic [2*N-1:0]   p_q;
  logic             busy_q;
  logic             done_q;

  logic [N-1:0]     a_mag;
  logic [N-1:0]     b_mag;
  logic [N:0]       addend;
  logic [N:0]       sum;
  logic [2*N:0]     acc_d;
  logic [2*N-1:0]   prod_d;
  logic [2*N-1:0]   p_d;

  always_comb begin
    // Negating -2^(N-1) wraps back to itself, which read unsigned is 2^(N-1).
    a_mag  = (TC && A[N-1]) ? -A : A;
    b_mag  = (TC && B[N-1]) ? -B : B;
    addend = acc_q[0] ? {1'b0, mcand_q} : '0;
    sum    = acc_q[2*N:N] + addend;
    // Add-then-shift folded into one step: the multiplier LSB falls off the end.
    acc_d  = {1'b0, sum, acc_q[N-1:1]};
    prod_d = acc_d[2*N-1:0];
    p_d    = neg_q ? -prod_d : prod_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q <= a_mag;
            acc_q   <= {{(N+1){1'b0}}, b_mag};
            neg_q   <= TC & (A[N-1] ^ B[N-1]);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            p_q     <= p_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign P    = p_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
